// File: rtl/f_pc_unit_pkg.sv
// Fetch PC unit shared definitions.
// Decode op encodings and default vectors.
package f_pc_unit_pkg;

  typedef enum logic [2:0] {
    OP_SEQ   = 3'b000,
    OP_BR    = 3'b001,
    OP_J     = 3'b010,
    OP_JAL   = 3'b011,
    OP_JR    = 3'b100,
    OP_JR_RA = 3'b101
  } d_op_e;

  localparam logic [31:0] DEF_RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_VEC   = 32'h0000_4180;
  localparam int          DEF_RAS_DEPTH = 4;

endpackage

// File: rtl/f_ras.sv
// Return-address stack, circular on overflow.
// Used for checking/profiling only.
module f_ras #(
  parameter int RAS_DEPTH = 4,
  parameter int W         = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW:0] FULLC = (PW+1)'(RAS_DEPTH);

  logic [PW-1:0] sp;
  logic [PW-1:0] tp;
  logic [PW:0]   cnt;
  logic [W-1:0]  mem [RAS_DEPTH];

  assign tp    = sp - PW'(1);
  assign top   = mem[tp];
  assign empty = (cnt == '0);
  assign full  = (cnt == FULLC);

  // when full, sp already points at the oldest slot
  always_ff @(posedge clk) begin
    if (push) mem[sp] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp  <= '0;
      cnt <= '0;
    end else if (push) begin
      sp <= sp + PW'(1);
      if (!full) cnt <= cnt + (PW+1)'(1);
    end else if (pop && !empty) begin
      sp  <= tp;
      cnt <= cnt - (PW+1)'(1);
    end
  end

endmodule

// File: rtl/f_pc_unit.sv
// Fetch PC unit: next-PC select, EPC,
// and a RAS-based return predictor monitor.
module f_pc_unit
  import f_pc_unit_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter logic [PC_W-1:0] RESET_PC  = PC_W'(DEF_RESET_PC),
  parameter logic [PC_W-1:0] EXC_VEC   = PC_W'(DEF_EXC_VEC),
  parameter int              RAS_DEPTH = DEF_RAS_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            d_valid,
  input  logic [2:0]      d_op,
  input  logic            d_taken,
  input  logic [PC_W-1:0] d_pc,
  input  logic [15:0]     imm16,
  input  logic [25:0]     imm26,
  input  logic [PC_W-1:0] rs_val,
  input  logic            exc_req,
  input  logic [PC_W-1:0] exc_pc,
  input  logic            eret,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc4,
  output logic            flush,
  output logic [PC_W-1:0] epc,
  output logic            ras_miss,
  output logic [15:0]     miss_cnt
);

  logic [PC_W-1:0] dpc4;
  logic [PC_W-1:0] br_tgt;
  logic [PC_W-1:0] j_tgt;
  logic [PC_W-1:0] tgt;
  logic [PC_W-1:0] npc;
  logic            redir;
  logic            ras_ok;
  logic            push;
  logic            pop;
  logic            miss_d;
  logic [PC_W-1:0] ras_top;
  logic            ras_empty;
  logic            ras_full;

  assign pc4    = pc + PC_W'(4);
  assign dpc4   = d_pc + PC_W'(4);
  assign br_tgt = dpc4 +
    {{(PC_W-18){imm16[15]}}, imm16, 2'b00};
  assign j_tgt  = {dpc4[PC_W-1:28], imm26, 2'b00};

  always_comb begin
    redir = 1'b0;
    tgt   = dpc4;
    if (d_valid) begin
      case (d_op)
        OP_BR: begin
          redir = d_taken;
          tgt   = br_tgt;
        end
        OP_J, OP_JAL: begin
          redir = 1'b1;
          tgt   = j_tgt;
        end
        OP_JR, OP_JR_RA: begin
          redir = 1'b1;
          tgt   = rs_val;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    if (exc_req)    npc = EXC_VEC;
    else if (eret)  npc = epc;
    else if (stall) npc = pc;
    else if (redir) npc = tgt;
    else            npc = pc4;
  end

  assign flush = exc_req | eret | (redir & ~stall);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc  <= RESET_PC;
      epc <= '0;
    end else begin
      pc <= npc;
      if (exc_req) epc <= exc_pc;
    end
  end

  // exceptions and erets never disturb the stack
  assign ras_ok = d_valid & ~stall & ~exc_req & ~eret;
  assign push   = ras_ok & (d_op == OP_JAL);
  assign pop    = ras_ok & (d_op == OP_JR_RA);
  assign miss_d = pop & (ras_empty | (ras_top != rs_val));

  f_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .W         (PC_W)
  ) u_ras (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (dpc4),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ras_miss <= 1'b0;
      miss_cnt <= '0;
    end else if (stall) begin
      ras_miss <= 1'b0;
    end else begin
      ras_miss <= miss_d;
      if (miss_d && miss_cnt != 16'hFFFF)
        miss_cnt <= miss_cnt + 16'd1;
    end
  end

endmodule
